// File: rtl/bm_dag2_log_pipe.sv
// Two-stage valid/ready logic pipeline: S1 registers the a/b and c/d branch values,
// S2 combines them into out0/out1 and numbers each delivered result with out_cnt.
module bm_dag2_log_pipe #(
    parameter int BITS  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  a_in,
    input  logic [BITS-1:0]  b_in,
    input  logic [BITS-1:0]  c_in,
    input  logic [BITS-1:0]  d_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out0,
    output logic             out1,
    output logic [CNT_W-1:0] out_cnt
);

    // Handshake: a side transfers when valid && ready. The only back-pressure is a
    // held result (stall); then both stages freeze and in_ready drops.
    logic             stall;
    logic             in_fire;
    logic             out_fire;

    logic             v1_q;
    logic [BITS-1:0]  ta_q, tb_q, tc_q, td_q;
    logic [1:0]       mode_q;
    logic             out_valid_q;
    logic [BITS-1:0]  out0_q, out0_d;
    logic             out1_q, out1_d;
    logic [CNT_W-1:0] cnt_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out0_d = '0;
        unique case (mode_q)
            2'd0: out0_d = ta_q & tb_q;
            2'd1: out0_d = ta_q | tb_q;
            2'd2: out0_d = ta_q ^ tb_q;
            2'd3: out0_d = ~(ta_q & tb_q);
            default: out0_d = '0;
        endcase
        out1_d = |(tc_q | td_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            ta_q        <= '0;
            tb_q        <= '0;
            tc_q        <= '0;
            td_q        <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (!stall) begin
                v1_q <= in_fire;
                // S1 only reloads on an accept, so an empty stage keeps its last operands.
                if (in_fire) begin
                    ta_q   <= a_in & b_in;
                    tb_q   <= a_in ^ (a_in | b_in);
                    tc_q   <= (c_in & d_in) ^ d_in;
                    td_q   <= c_in ^ d_in;
                    mode_q <= mode;
                end
                out_valid_q <= v1_q;
                if (v1_q) begin
                    out0_q <= out0_d;
                    out1_q <= out1_d;
                end
            end
            if (out_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_bm_dag2_log_pipe.sv
// Scoreboard bench for bm_dag2_log_pipe (BITS=8, CNT_W=2): the driver pushes
// hand-computed results on accept, a monitor pops and compares on each output transfer.
module tb_bm_dag2_log_pipe;

    localparam int BITS  = 8;
    localparam int CNT_W = 2;
    localparam int EXP_W = BITS + 1 + CNT_W;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  a_in, b_in, c_in, d_in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out0;
    logic             out1;
    logic [CNT_W-1:0] out_cnt;

    logic [EXP_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_checks;
    int               n_fail;

    bm_dag2_log_pipe #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out_cnt   (out_cnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // driver: present one operand set and push its expected result when accepted
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [1:0] m,
                        input logic [7:0] e0, input logic e1);
        bit done;
        done     = 1'b0;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        d_in     = d;
        mode     = m;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({e0, e1, exp_cnt});
                exp_cnt = exp_cnt + 1'b1;
                done    = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
        end
    endtask

    // monitor: scoreboard pop on output transfer, plus in_ready back-pressure rule
    always @(negedge clock) begin
        if (reset_n) begin
            check("in_ready_vs_stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: out0=0x%0h out1=%0d out_cnt=%0d with empty queue",
                             out0, out1, out_cnt);
                end else begin
                    logic [EXP_W-1:0] e;
                    e = exp_q.pop_front();
                    check("out0", 32'(out0), 32'(e[EXP_W-1 -: BITS]));
                    check("out1", 32'(out1), 32'(e[CNT_W]));
                    check("out_cnt", 32'(out_cnt), 32'(e[CNT_W-1:0]));
                end
            end
        end
    end

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_cnt   = '0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; mode = '0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_out1", 32'(out1), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single accept: ta = 0x30, tb = ~a & b = 0x0C, mode 0 -> 0x00; latency check.
        send(8'hF0, 8'h3C, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0);
        @(negedge clock);
        check("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back mode changes on the same a/b; c^d drives out1; 5th result wraps out_cnt.
        send(8'hF0, 8'h3C, 8'h01, 8'h00, 2'd1, 8'h3C, 1'b1);
        send(8'hF0, 8'h3C, 8'h00, 8'h00, 2'd2, 8'h3C, 1'b0);
        send(8'hF0, 8'h3C, 8'h00, 8'h40, 2'd3, 8'hFF, 1'b1);
        send(8'hAA, 8'h55, 8'h80, 8'h80, 2'd2, 8'h55, 1'b0);
        drain();
        check("hold_out_valid_low", 32'(out_valid), 32'd0);
        check("hold_out0_last", 32'(out0), 32'h55);
        check("hold_out1_last", 32'(out1), 32'd0);

        // Stall: out_ready low for 5 cycles while 3 accepts are attempted.
        out_ready = 1'b0;
        fork
            begin
                send(8'h0F, 8'hFF, 8'h12, 8'h12, 2'd0, 8'h00, 1'b0);
                send(8'h0F, 8'hFF, 8'hFF, 8'h00, 2'd1, 8'hFF, 1'b1);
                send(8'h33, 8'h0F, 8'h00, 8'h40, 2'd2, 8'h0F, 1'b1);
            end
            begin
                repeat (4) @(posedge clock);
                @(negedge clock);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_head_out0", 32'(out0), 32'h00);
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight: asynchronous clear, no stale output afterward.
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 8'h01, 8'h02, 2'd3, 8'hFF, 1'b1);
        send(8'h0F, 8'hF0, 8'h00, 8'h00, 2'd1, 8'hF0, 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_cnt", 32'(out_cnt), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_cnt = '0;
        out_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_no_output", 32'(out_valid), 32'd0);

        // First result after reset is numbered 0 again.
        send(8'hC3, 8'h3C, 8'h00, 8'h08, 2'd2, 8'h3C, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
